ctrl_multiciclo: RTL



---
 rtl/ctrl_multiciclo.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_multiciclo.sv
// rtl/ctrl_multiciclo.sv - multi-cycle control sequencer for the RV32 lw/sw/sub/xor/addi/srl/beq subset
//
// Owns the PC and walks each instruction through IF/ID/EX/MEM/WB.
// It emits one registered, one-cycle strobe per phase.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             leave IDLE/HALT and restart at PC_RESET
//   instr             instruction word, captured when imem_ready=1 in IF
//   imem_ready        instruction memory data valid
//   dmem_ready        data memory access complete
//   alu_zero          ALU zero flag, sampled in PCUPD for beq
//   pc                current PC
//   if_en .. wb_en    one-cycle phase strobes
//   mem_req           data memory request, high for every MEM cycle
//   state             current state encoding
//   halted            sequencer is in HALT
//   err               halted on an illegal opcode or misaligned target
//   instr_count       retired instructions, saturating
//
// Optional build macro PC_ALIGN_CHECK_EN:
//   A taken branch whose target has nonzero bits [1:0] halts with err=1.
//   In that case the PC and the counter are left untouched.
module ctrl_multiciclo #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   PC_RESET = '0,
    parameter int                EX_WAIT  = 2,
    parameter int                WB_WAIT  = 2,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              alu_zero,
    output logic [XLEN-1:0]   pc,
    output logic              if_en,
    output logic              id_en,
    output logic              ex_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              mem_req,
    output logic [3:0]        state,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_IF    = 4'd1,
        S_ID    = 4'd2,
        S_EX    = 4'd3,
        S_EXW   = 4'd4,
        S_MEM   = 4'd5,
        S_WB    = 4'd6,
        S_WBW   = 4'd7,
        S_PCUPD = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The wait counters count down to zero.
    // Loading N-1 therefore holds the wait state for exactly N cycles.
    localparam logic [3:0] EX_LOAD = (EX_WAIT > 0) ? 4'(EX_WAIT - 1) : 4'd0;
    localparam logic [3:0] WB_LOAD = (WB_WAIT > 0) ? 4'(WB_WAIT - 1) : 4'd0;

    state_t          st;
    logic [31:0]     ir;
    logic [3:0]      wcnt;

    logic [6:0]      opcode;
    logic            is_load;
    logic            is_mem;
    logic            is_branch;
    logic            legal;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] br_target;
    logic            br_taken;
    logic            misalign;
    state_t          ex_next;

    assign state = st;

    assign opcode    = ir[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_mem    = is_load || (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign legal     = is_mem || is_branch || (opcode == OP_R) || (opcode == OP_I);

    // The B-type immediate is 13 bits, with bit 12 (ir[31]) as the sign.
    assign b_imm     = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign br_target = pc + b_imm;
    assign br_taken  = is_branch && (ir[14:12] == 3'b000) && alu_zero;

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = br_taken && (br_target[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        ex_next = S_WB;
        if (is_mem)
            ex_next = S_MEM;
        else if (is_branch)
            ex_next = S_PCUPD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            pc          <= PC_RESET;
            ir          <= '0;
            wcnt        <= '0;
            instr_count <= '0;
            if_en       <= 1'b0;
            id_en       <= 1'b0;
            ex_en       <= 1'b0;
            mem_en      <= 1'b0;
            wb_en       <= 1'b0;
            mem_req     <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Each strobe is raised only on the edge that enters its phase.
            // A strobe therefore lasts exactly one cycle.
            if_en  <= 1'b0;
            id_en  <= 1'b0;
            ex_en  <= 1'b0;
            mem_en <= 1'b0;
            wb_en  <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (start) begin
                        st    <= S_IF;
                        pc    <= PC_RESET;
                        if_en <= 1'b1;
                    end
                end

                S_IF: begin
                    if (imem_ready) begin
                        ir    <= instr;
                        st    <= S_ID;
                        id_en <= 1'b1;
                    end
                end

                S_ID: begin
                    if (ir == 32'd0) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                        err    <= 1'b0;
                    end else if (!legal) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        st    <= S_EX;
                        ex_en <= 1'b1;
                    end
                end

                S_EX, S_EXW: begin
                    if (st == S_EX && EX_WAIT != 0) begin
                        st   <= S_EXW;
                        wcnt <= EX_LOAD;
                    end else if (st == S_EX || wcnt == 4'd0) begin
                        st      <= ex_next;
                        mem_en  <= (ex_next == S_MEM);
                        mem_req <= (ex_next == S_MEM);
                        wb_en   <= (ex_next == S_WB);
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end

                S_MEM: begin
                    if (dmem_ready) begin
                        mem_req <= 1'b0;
                        if (is_load) begin
                            st    <= S_WB;
                            wb_en <= 1'b1;
                        end else begin
                            st <= S_PCUPD;
                        end
                    end
                end

                S_WB, S_WBW: begin
                    if (st == S_WB && WB_WAIT != 0) begin
                        st   <= S_WBW;
                        wcnt <= WB_LOAD;
                    end else if (st == S_WB || wcnt == 4'd0) begin
                        st <= S_PCUPD;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end

                S_PCUPD: begin
                    if (misalign) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        pc <= br_taken ? br_target : pc + XLEN'(4);
                        if (instr_count != {CNT_W{1'b1}})
                            instr_count <= instr_count + CNT_W'(1);
                        st    <= S_IF;
                        if_en <= 1'b1;
                    end
                end

                S_HALT: begin
                    if (start) begin
                        st     <= S_IF;
                        pc     <= PC_RESET;
                        err    <= 1'b0;
                        halted <= 1'b0;
                        if_en  <= 1'b1;
                    end
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
